// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM slave bus bundle for the USB reset sequencer.
// The host side uses the master modport and the sequencer uses the slave modport.
interface usb_rst_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/usb_rst_sequencer.sv
// USB controller reset sequencer.
// It turns the synchronized USB-reset PIO level into a reset pulse of guaranteed
// minimum width, then waits a recovery time before it reports ready. A small
// register block provides status, a software kick, timing overrides and a done
// interrupt.
module usb_rst_sequencer #(
    parameter int CNT_W          = 16,
    parameter int PULSE_CYCLES   = 500,
    parameter int RECOVER_CYCLES = 5000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_rst_req,
    usb_rst_sequencer_if.slave bus,
    output logic               o_usb_rst_n,
    output logic               o_ready,
    output logic               o_irq
);
    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RECOVER = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;

    localparam logic [CNT_W-1:0] PULSE_RST   = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] RECOVER_RST = CNT_W'(RECOVER_CYCLES);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic             r_s1, r_s2, r_s3;
    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CNT_W-1:0] r_pulse_len, r_recover_len;
    logic [CNT_W-1:0] r_plen_l, r_rlen_l;
    logic [CNT_W-1:0] w_plen_eff, w_rlen_eff;
    logic             r_done, r_irq_en;
    logic             r_usb_rst_n, r_ready, r_irq;
    logic             w_req_lvl, w_req_rise;
    logic             w_wr, w_ctrl_wr, w_kick, w_clr, w_start;
    logic             w_enter_assert, w_enter_recover, w_set_done;
    logic             w_done_nxt, w_irq_en_nxt, w_busy;
    logic             w_unused;

    assign w_req_lvl  = r_s2;
    assign w_req_rise = r_s2 & ~r_s3;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_ctrl_wr = w_wr & (bus.address == 2'd1);
    assign w_kick    = w_ctrl_wr & bus.writedata[0];
    assign w_clr     = w_ctrl_wr & bus.writedata[1];
    // A PIO rising edge and a software kick in the same cycle merge into one start.
    assign w_start   = w_req_rise | w_kick;

    // A latched length of zero behaves as one cycle.
    assign w_plen_eff = (r_plen_l == '0) ? ONE : r_plen_l;
    assign w_rlen_eff = (r_rlen_l == '0) ? ONE : r_rlen_l;

    // The counter saturates instead of wrapping while a long request holds ASSERT.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + ONE;

    assign w_busy   = (r_state != S_READY);
    assign w_unused = &{1'b0, bus.writedata[31:CNT_W]};

    // Three-flop synchronizer for the asynchronous PIO level; s3 exists for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_rst_req;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Next-state logic: ASSERT ignores start; a start during RECOVER takes priority over completion.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_enter_assert  = 1'b0;
        w_enter_recover = 1'b0;
        w_set_done      = 1'b0;
        case (r_state)
            S_ASSERT: begin
                if ((r_cnt >= w_plen_eff - ONE) && !w_req_lvl) begin
                    w_state_nxt     = S_RECOVER;
                    w_cnt_nxt       = '0;
                    w_enter_recover = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RECOVER: begin
                if (w_start) begin
                    w_state_nxt    = S_ASSERT;
                    w_cnt_nxt      = '0;
                    w_enter_assert = 1'b1;
                end else if (r_cnt >= w_rlen_eff - ONE) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = '0;
                    w_set_done  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_READY: begin
                if (w_start) begin
                    w_state_nxt    = S_ASSERT;
                    w_cnt_nxt      = '0;
                    w_enter_assert = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_ASSERT;
                w_cnt_nxt      = '0;
                w_enter_assert = 1'b1;
            end
        endcase
    end

    // State, counter, phase-length latches and the registered reset/ready outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_ASSERT;
            r_cnt       <= '0;
            r_plen_l    <= PULSE_RST;
            r_rlen_l    <= RECOVER_RST;
            r_usb_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter_assert) begin
                r_plen_l <= r_pulse_len;
            end
            if (w_enter_recover) begin
                r_rlen_l <= r_recover_len;
            end
            r_usb_rst_n <= (w_state_nxt != S_ASSERT);
            r_ready     <= (w_state_nxt == S_READY);
        end
    end

    // A done event beats a same-cycle clear; irq follows the next done/enable values.
    assign w_done_nxt   = w_set_done | (r_done & ~w_clr);
    assign w_irq_en_nxt = w_ctrl_wr ? bus.writedata[2] : r_irq_en;

    // Software-visible registers and the registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_len   <= PULSE_RST;
            r_recover_len <= RECOVER_RST;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (w_wr && (bus.address == 2'd2)) begin
                r_pulse_len <= bus.writedata[CNT_W-1:0];
            end
            if (w_wr && (bus.address == 2'd3)) begin
                r_recover_len <= bus.writedata[CNT_W-1:0];
            end
            r_irq_en <= w_irq_en_nxt;
            r_done   <= w_done_nxt;
            r_irq    <= w_done_nxt & w_irq_en_nxt;
        end
    end

    // Zero-wait read mux; bits that are not defined read as zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[3:0]       = {r_usb_rst_n, r_done, w_busy, r_ready};
            2'd1:    bus.readdata[2]         = r_irq_en;
            2'd2:    bus.readdata[CNT_W-1:0] = r_pulse_len;
            default: bus.readdata[CNT_W-1:0] = r_recover_len;
        endcase
    end

    assign o_usb_rst_n = r_usb_rst_n;
    assign o_ready     = r_ready;
    assign o_irq       = r_irq;
endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Testbench for usb_rst_sequencer: directed scenarios, a register table,
// and randomized traffic checked against a behavioural phase model.
module tb_usb_rst_sequencer;
    localparam int PC    = 4;
    localparam int RC    = 6;
    localparam int LIMIT = 300;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_IDLE  = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rst_req = 1'b0;
    logic o_usb_rst_n, o_ready, o_irq;

    usb_rst_sequencer_if bus_if();

    usb_rst_sequencer #(
        .CNT_W          (16),
        .PULSE_CYCLES   (PC),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rst_req   (rst_req),
        .bus         (bus_if),
        .o_usb_rst_n (o_usb_rst_n),
        .o_ready     (o_ready),
        .o_irq       (o_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model: which phase the output is in, how many whole cycles it
    // has lasted, and how long it must last.
    bit          m_pipe[$];
    int          m_phase;
    int          m_elapsed;
    int          m_need;
    logic [15:0] m_plen_reg;
    logic [15:0] m_rlen_reg;
    bit          m_done;
    bit          m_irq_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'({16'd0, v});
    endfunction

    task automatic model_reset();
        m_pipe     = {1'b0, 1'b0, 1'b0};
        m_phase    = PH_PULSE;
        m_elapsed  = 0;
        m_plen_reg = 16'(PC);
        m_rlen_reg = 16'(RC);
        m_need     = eff(m_plen_reg);
        m_done     = 1'b0;
        m_irq_en   = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, (m_phase != PH_PULSE), m_done, (m_phase != PH_IDLE), (m_phase == PH_IDLE)};
            2'd1:    return {29'd0, m_irq_en, 2'b00};
            2'd2:    return {16'd0, m_plen_reg};
            default: return {16'd0, m_rlen_reg};
        endcase
    endfunction

    // Model update on each clock, using the inputs presented before the edge.
    initial begin : model
        bit wr, lvl, rise, start, clr, fin;
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                wr    = bus_if.chipselect && !bus_if.write_n;
                lvl   = m_pipe[1];
                rise  = m_pipe[1] && !m_pipe[2];
                start = rise || (wr && bus_if.address == 2'd1 && bus_if.writedata[0]);
                clr   = wr && bus_if.address == 2'd1 && bus_if.writedata[1];
                fin   = 1'b0;
                if (m_phase == PH_PULSE) begin
                    m_elapsed++;
                    if (m_elapsed >= m_need && !lvl) begin
                        m_phase   = PH_WAIT;
                        m_elapsed = 0;
                        m_need    = eff(m_rlen_reg);
                    end
                end else if (start) begin
                    m_phase   = PH_PULSE;
                    m_elapsed = 0;
                    m_need    = eff(m_plen_reg);
                end else if (m_phase == PH_WAIT) begin
                    m_elapsed++;
                    if (m_elapsed >= m_need) begin
                        m_phase = PH_IDLE;
                        fin     = 1'b1;
                    end
                end
                if (wr) begin
                    case (bus_if.address)
                        2'd1:    m_irq_en   = bus_if.writedata[2];
                        2'd2:    m_plen_reg = bus_if.writedata[15:0];
                        2'd3:    m_rlen_reg = bus_if.writedata[15:0];
                        default: ;
                    endcase
                end
                m_done = fin || (m_done && !clr);
                m_pipe.push_front(rst_req);
                void'(m_pipe.pop_back());
            end
        end
    end

    // Continuous comparison of the registered outputs against the model.
    initial begin : checker_proc
        forever begin
            @(negedge clk);
            if (chk_on && reset_n) begin
                chk1("model_usb_rst_n", o_usb_rst_n, (m_phase != PH_PULSE));
                chk1("model_ready", o_ready, (m_phase == PH_IDLE));
                chk1("model_irq", o_irq, (m_done && m_irq_en));
            end
        end
    end

    task automatic bus_idle();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = 32'd0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = a;
        #1;
        d = bus_if.readdata;
        bus_idle();
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (!o_usb_rst_n && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_recover(output int n);
        n = 0;
        while (!o_ready && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Raise rst_req for 'hold' cycles; report edges to the fall, low width,
    // edges from the request drop to the rise, and ready-high samples while low.
    task automatic req_pulse(input int hold, output int lat, output int width,
                             output int after, output int rdy_bad);
        int n;
        n       = 0;
        lat     = -1;
        width   = 0;
        rdy_bad = 0;
        rst_req = 1'b1;
        while (n < LIMIT) begin
            @(negedge clk);
            n++;
            if (n == hold) rst_req = 1'b0;
            if (!o_usb_rst_n) begin
                width++;
                if (lat < 0) lat = n;
                if (o_ready) rdy_bad++;
            end else if (lat >= 0) begin
                break;
            end
        end
        rst_req = 1'b0;
        after   = n - hold;
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin : main
        vec_t        tbl[10];
        logic [31:0] rd;
        int          lat, width, after, rbad, r;

        tbl[0] = '{1'b1, 2'd2, 32'h0000_1234, 32'h0000_1234};
        tbl[1] = '{1'b1, 2'd2, 32'hFFFF_ABCD, 32'h0000_ABCD};
        tbl[2] = '{1'b1, 2'd3, 32'h0000_0007, 32'h0000_0007};
        tbl[3] = '{1'b1, 2'd1, 32'h0000_0004, 32'h0000_0004};
        tbl[4] = '{1'b1, 2'd1, 32'hFFFF_FFF8, 32'h0000_0000};
        tbl[5] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_000D};
        tbl[6] = '{1'b1, 2'd1, 32'h0000_0002, 32'h0000_0000};
        tbl[7] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0009};
        tbl[8] = '{1'b1, 2'd2, 32'h0000_0004, 32'h0000_0004};
        tbl[9] = '{1'b1, 2'd3, 32'h0000_0006, 32'h0000_0006};

        bus_idle();
        repeat (3) @(negedge clk);
        chk1("reset_usb_rst_n", o_usb_rst_n, 1'b0);
        chk1("reset_ready", o_ready, 1'b0);
        chk1("reset_irq", o_irq, 1'b0);
        chk_on = 1'b1;

        // Power-on pulse and recovery with default lengths.
        #2 reset_n = 1'b1;
        measure_low(width);
        chk("poweron_pulse_width", width, PC);
        measure_recover(width);
        chk("poweron_recover_width", width, RC);
        bus_read(2'd0, rd);
        chk("poweron_status", rd, 32'h0000_000D);

        // Register table.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
            bus_read(tbl[i].addr, rd);
            chk($sformatf("table_%0d", i), rd, tbl[i].exp);
        end

        // Short PIO pulse: pulse length governs.
        bus_write(2'd2, 32'd10);
        req_pulse(2, lat, width, after, rbad);
        chk("short_req_latency", lat, 3);
        chk("short_req_width", width, 10);
        chk("short_req_ready_low", rbad, 0);
        measure_recover(width);
        chk("short_req_recover", width, RC);

        // Long PIO request stretches the pulse.
        req_pulse(50, lat, width, after, rbad);
        chk("long_req_latency", lat, 3);
        chk("long_req_width", width, 50);
        chk("long_req_drop_to_rise", after, 3);
        measure_recover(width);
        chk("long_req_recover", width, RC);

        // Kick during RECOVER restarts a full pulse; a kick during ASSERT is ignored.
        bus_write(2'd3, 32'd20);
        bus_write(2'd1, 32'd1);
        measure_low(width);
        chk("kick_pulse_width", width, 10);
        repeat (5) @(negedge clk);
        bus_write(2'd1, 32'd1);
        chk1("kick_recover_usb_low", o_usb_rst_n, 1'b0);
        chk1("kick_recover_ready_low", o_ready, 1'b0);
        width = 0;
        while (!o_usb_rst_n && width < LIMIT) begin
            width++;
            if (width == 3) begin
                bus_if.chipselect = 1'b1;
                bus_if.write_n    = 1'b0;
                bus_if.address    = 2'd1;
                bus_if.writedata  = 32'd1;
            end else begin
                bus_idle();
            end
            @(negedge clk);
        end
        bus_idle();
        chk("kick_in_assert_width", width, 10);
        measure_recover(width);
        chk("kick_recover_width", width, 20);

        // Interrupt enable, done, clear.
        bus_write(2'd1, 32'd2);
        chk1("irq_after_clear", o_irq, 1'b0);
        bus_write(2'd1, 32'd4);
        chk1("irq_en_no_done", o_irq, 1'b0);
        bus_write(2'd1, 32'd5);
        measure_low(width);
        measure_recover(width);
        chk1("irq_on_done", o_irq, 1'b1);
        bus_write(2'd1, 32'd6);
        chk1("irq_cleared", o_irq, 1'b0);
        bus_read(2'd1, rd);
        chk("irq_en_kept", rd, 32'h0000_0004);
        bus_read(2'd0, rd);
        chk("status_after_clear", rd, 32'h0000_0009);

        // Clear on the same edge as the READY transition: set wins.
        bus_write(2'd1, 32'd5);
        measure_low(width);
        repeat (19) @(negedge clk);
        bus_write(2'd1, 32'd6);
        chk1("collide_ready", o_ready, 1'b1);
        chk1("collide_irq", o_irq, 1'b1);
        bus_read(2'd0, rd);
        chk("collide_status", rd, 32'h0000_000D);
        bus_write(2'd1, 32'd2);

        // Zero pulse length gives a one-cycle pulse; then async reset mid-RECOVER.
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'd1);
        measure_low(width);
        chk("zero_len_pulse_width", width, 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk1("async_reset_usb_rst_n", o_usb_rst_n, 1'b0);
        chk1("async_reset_ready", o_ready, 1'b0);
        chk1("async_reset_irq", o_irq, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        bus_read(2'd2, rd);
        chk("reset_plen_default", rd, 32'(PC));
        measure_low(width);
        chk("repower_pulse_width", width, PC);
        measure_recover(width);
        chk("repower_recover_width", width, RC);

        // Randomized traffic against the model.
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'd4);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) rst_req = ~rst_req;
            r = int'($urandom_range(0, 39));
            bus_if.chipselect = 1'b1;
            bus_if.write_n    = 1'b0;
            if (r == 0) begin
                bus_if.address   = 2'd1;
                bus_if.writedata = {29'd0, 3'($urandom_range(0, 7))};
            end else if (r == 1) begin
                bus_if.address   = 2'd2;
                bus_if.writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            end else if (r == 2) begin
                bus_if.address   = 2'd3;
                bus_if.writedata = 32'($urandom_range(0, 8));
            end else if (r == 3) begin
                bus_if.address   = 2'd0;
                bus_if.writedata = $urandom;
            end else if (r < 6) begin
                bus_if.address   = 2'd1;
                bus_if.writedata = 32'd1 | (32'($urandom_range(0, 1)) << 2);
            end else begin
                bus_if.chipselect = 1'($urandom_range(0, 1));
                bus_if.write_n    = 1'b1;
                bus_if.address    = 2'($urandom_range(0, 3));
                bus_if.writedata  = $urandom;
            end
            #1;
            chk("rand_readdata", bus_if.readdata, model_read(bus_if.address));
            @(negedge clk);
        end
        rst_req = 1'b0;
        bus_idle();
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
